// File: rtl/lsu_mem_if.sv
// Load/store unit: byte-addressed RISC-V loads/stores to a word-addressed memory,
// sub-word stores by read-modify-write. Define LSU_STATS_EN to enable event counters.
module lsu_mem_if #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] m_addr,
    output logic [31:0] m_wr_dat,
    output logic        rd_en,
    output logic        wr_en,
    input  logic [31:0] m_rd_dat,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores,
    output logic [15:0] stat_errs
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [IDX_W+1:0] addr_q, addr_d;
    logic [31:0]      wdat_q, wdat_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             f3_bad;
    logic             misaligned;
    logic             out_of_range;
    logic             acc_err;
    logic [31:0]      byte_sh;
    logic [31:0]      half_sh;
    logic [31:0]      ld_val;
    logic [31:0]      merged;
    logic [31:0]      lane_mask;
    logic [31:0]      lane_data;

    // Request legality, evaluated combinationally on the incoming request.
    always_comb begin
        f3_bad = 1'b1;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
            3'b100, 3'b101:         f3_bad = req_we;
            default:                f3_bad = 1'b1;
        endcase
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr >> 2) >= 32'(DEPTH_WORDS);
        acc_err      = f3_bad || misaligned || out_of_range;
    end

    // Lane selection and extension for loads; lane merge for sub-word stores.
    always_comb begin
        byte_sh = m_rd_dat >> {addr_q[1:0], 3'b000};
        half_sh = m_rd_dat >> {addr_q[1], 4'b0000};
        case (f3_q)
            3'b000:  ld_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  ld_val = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b100:  ld_val = {24'd0, byte_sh[7:0]};
            3'b101:  ld_val = {16'd0, half_sh[15:0]};
            default: ld_val = m_rd_dat;
        endcase
        if (f3_q[1:0] == 2'b00) begin
            lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
            lane_data = {24'd0, wdat_q[7:0]} << {addr_q[1:0], 3'b000};
        end else begin
            lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
            lane_data = {16'd0, wdat_q[15:0]} << {addr_q[1], 4'b0000};
        end
        merged = (m_rd_dat & ~lane_mask) | lane_data;
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[IDX_W+1:0];
                    wdat_d  = req_wdata;
                    rdata_d = '0;
                    err_d   = acc_err;
                    if (acc_err)
                        state_d = S_RESP;
                    else if (req_we && (req_funct3 == 3'b010))
                        state_d = S_WR_REQ;
                    else
                        state_d = S_RD_REQ;
                end
            end
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                // Stores reuse the write-data register to hold the merged word.
                if (we_q) begin
                    wdat_d  = merged;
                    state_d = S_WR_REQ;
                end else begin
                    rdata_d = ld_val;
                    state_d = S_RESP;
                end
            end
            S_WR_REQ:  state_d = S_RESP;
            S_RESP:    if (resp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign rd_en      = (state_q == S_RD_REQ);
    assign wr_en      = (state_q == S_WR_REQ);
    assign m_addr     = 32'(addr_q[IDX_W+1:2]);
    assign m_wr_dat   = wdat_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

`ifdef LSU_STATS_EN
    logic [15:0] ld_cnt_q, ld_cnt_d;
    logic [15:0] st_cnt_q, st_cnt_d;
    logic [15:0] er_cnt_q, er_cnt_d;

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        er_cnt_d = er_cnt_q;
        if ((state_q == S_RESP) && resp_ready) begin
            if (err_q) begin
                if (er_cnt_q != '1) er_cnt_d = er_cnt_q + 16'd1;
            end else if (we_q) begin
                if (st_cnt_q != '1) st_cnt_d = st_cnt_q + 16'd1;
            end else begin
                if (ld_cnt_q != '1) ld_cnt_d = ld_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
            er_cnt_q <= '0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
            er_cnt_q <= er_cnt_d;
        end
    end

    assign stat_loads  = ld_cnt_q;
    assign stat_stores = st_cnt_q;
    assign stat_errs   = er_cnt_q;
`else
    assign stat_loads  = '0;
    assign stat_stores = '0;
    assign stat_errs   = '0;
`endif

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if: directed plan cases plus randomized traffic
// checked against a byte-level reference memory model.
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] m_addr;
    logic [31:0] m_wr_dat;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] m_rd_dat;
    logic [15:0] stat_loads, stat_stores, stat_errs;

    always #5 clk = ~clk;

    lsu_mem_if #(.DEPTH_WORDS(1024), .IDX_W(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_addr(m_addr), .m_wr_dat(m_wr_dat), .rd_en(rd_en), .wr_en(wr_en),
        .m_rd_dat(m_rd_dat),
        .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
    );

    // Data memory: synchronous read, one-cycle latency; writes on wr_en.
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] mrd = '0;
    int unsigned rd_cnt = 0, wr_cnt = 0;
    logic [31:0] last_wr_addr = '0, last_wr_dat = '0;
    assign m_rd_dat = mrd;

    always @(posedge clk) begin
        if (rd_en) begin
            mrd <= mem[m_addr[9:0]];
            rd_cnt++;
        end
        if (wr_en) begin
            mem[m_addr[9:0]] = m_wr_dat;
            last_wr_addr = m_addr;
            last_wr_dat = m_wr_dat;
            wr_cnt++;
        end
    end

    int errors = 0, checks = 0;
    int exp_loads = 0, exp_stores = 0, exp_errs = 0;

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int unsigned size;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
        size = 1 << f3[1:0];
        if ((addr % size) != 0) return 1'b1;
        if (addr >= 32'd4096) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input int off);
        logic [7:0]  b [4];
        logic [31:0] v;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        case (f3)
            3'd0: begin v = 32'(b[off]); if (v >= 32'd128) v = v + 32'hFFFF_FF00; end
            3'd4: v = 32'(b[off]);
            3'd1: begin v = 32'(b[off]) + 32'(b[off+1]) * 256; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
            3'd5: v = 32'(b[off]) + 32'(b[off+1]) * 256;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3, input int off,
                                              input logic [31:0] wd);
        logic [7:0]  b [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        if (f3 == 3'd2) return wd;
        b[off] = wd[7:0];
        if (f3 == 3'd1) b[off+1] = wd[15:8];
        r = '0;
        for (int i = 0; i < 4; i++) r = r + (32'(b[i]) << (8*i));
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int nrd, output int nwr);
        int unsigned rd0, wr0;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL accept_timeout req_ready=%0b required=1", req_ready);
        end
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
        rdata = resp_rdata; err = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        nrd = int'(rd_cnt - rd0);
        nwr = int'(wr_cnt - wr0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, rd_en, wr_en} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=10000", {req_ready, resp_valid, resp_err, rd_en, wr_en});
        end
        checks++;
        if ({resp_rdata, m_addr, m_wr_dat} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data rdata=%h m_addr=%h m_wr_dat=%h required=0", resp_rdata, m_addr, m_wr_dat);
        end
        checks++;
        if ({stat_loads, stat_stores, stat_errs} !== 48'd0) begin
            errors++;
            $display("FAIL reset_stats got=%h required=0", {stat_loads, stat_stores, stat_errs});
        end
        reset = 1'b1;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [31:0] adrs [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
        logic [31:0] exps [5] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB, 32'h8899_AABB};
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3s[i], adrs[i], 32'hDEAD_BEEF, rd, er, lat, nrd, nwr);
            exp_loads++;
            checks++;
            if (rd !== exps[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL load_%0d rdata=%h err=%b required rdata=%h err=0", i, rd, er, exps[i]);
            end
            checks++;
            if (lat != 3 || nrd != 1 || nwr != 0) begin
                errors++;
                $display("FAIL load_timing_%0d lat=%0d rd=%0d wr=%0d required 3/1/0", i, lat, nrd, nwr);
            end
        end
    endtask

    task automatic test_store_sb();
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        do_req(1'b1, 3'd0, 32'h11, 32'h1234_5677, rd, er, lat, nrd, nwr);
        exp_stores++;
        checks++;
        if (lat != 4 || nrd != 1 || nwr != 1 || er !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL sb_timing lat=%0d rd=%0d wr=%0d err=%b rdata=%h required 4/1/1/0/0", lat, nrd, nwr, er, rd);
        end
        checks++;
        if (last_wr_addr !== 32'd4 || last_wr_dat !== 32'h8899_77BB) begin
            errors++;
            $display("FAIL sb_write m_addr=%h m_wr_dat=%h required 4/889977bb", last_wr_addr, last_wr_dat);
        end
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
        exp_loads++;
        checks++;
        if (rd !== 32'h8899_77BB) begin
            errors++;
            $display("FAIL sb_readback rdata=%h required=889977bb", rd);
        end
        do_req(1'b1, 3'd2, 32'h10, 32'h8899_AABB, rd, er, lat, nrd, nwr);
        exp_stores++;
        checks++;
        if (lat != 2 || nrd != 0 || nwr != 1 || mem[4] !== 32'h8899_AABB) begin
            errors++;
            $display("FAIL sw lat=%0d rd=%0d wr=%0d mem4=%h required 2/0/1/8899aabb", lat, nrd, nwr, mem[4]);
        end
    endtask

    task automatic test_errors();
        logic [2:0]  f3s  [3] = '{3'd2, 3'd3, 3'd2};
        logic [31:0] adrs [3] = '{32'h12, 32'h10, 32'h1000};
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat, nrd, nwr);
            exp_errs++;
            checks++;
            if (er !== 1'b1 || rd !== 32'd0 || lat != 1 || nrd != 0 || nwr != 0) begin
                errors++;
                $display("FAIL err_%0d err=%b rdata=%h lat=%0d rd=%0d wr=%0d required 1/0/1/0/0",
                         i, er, rd, lat, nrd, nwr);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h8899_AABB || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d valid=%b rdata=%h ready=%b required 1/8899aabb/0",
                         c, resp_valid, resp_rdata, req_ready);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        exp_loads++;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release ready=%b valid=%b required 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_stats();
        logic [47:0] req;
`ifdef LSU_STATS_EN
        req = {16'(exp_loads), 16'(exp_stores), 16'(exp_errs)};
`else
        req = '0;
`endif
        checks++;
        if ({stat_loads, stat_stores, stat_errs} !== req) begin
            errors++;
            $display("FAIL stats got=%0d/%0d/%0d required=%0d/%0d/%0d", stat_loads, stat_stores, stat_errs,
                     req[47:32], req[31:16], req[15:0]);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned wr0;
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h10; req_wdata = 32'h0000_CAFE;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, rd_en, wr_en} !== 5'b10000 ||
            {resp_rdata, m_addr, m_wr_dat} !== 96'd0 || {stat_loads, stat_stores, stat_errs} !== 48'd0) begin
            errors++;
            $display("FAIL midreset_outputs ctrl=%b rdata=%h m_addr=%h m_wr_dat=%h required 10000/0/0/0",
                     {req_ready, resp_valid, resp_err, rd_en, wr_en}, resp_rdata, m_addr, m_wr_dat);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt != wr0 || mem[4] !== 32'h8899_AABB) begin
            errors++;
            $display("FAIL midreset_mem writes=%0d mem4=%h required 0/8899aabb", wr_cnt - wr0, mem[4]);
        end
        reset = 1'b1;
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
        do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
        exp_loads++;
        checks++;
        if (rd !== 32'h8899_AABB || er !== 1'b0 || lat != 3) begin
            errors++;
            $display("FAIL midreset_lw rdata=%h err=%b lat=%0d required 8899aabb/0/3", rd, er, lat);
        end
        test_stats();
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd, erd; logic er, ee, we; logic [2:0] f3;
        int lat, nrd, nwr, elat, enrd, enwr, idx, off;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       addr = 32'h1000 + $urandom_range(0, 255);
                1:       addr = $urandom | 32'h8000_0000;
                default: addr = $urandom_range(0, 63);
            endcase
            wd = $urandom;
            ee = ref_err(we, f3, addr);
            idx = int'(addr[11:2]); off = int'(addr[1:0]);
            erd = '0;
            if (ee) begin
                elat = 1; enrd = 0; enwr = 0; exp_errs++;
            end else if (!we) begin
                elat = 3; enrd = 1; enwr = 0; exp_loads++;
                erd = ref_load(ref_mem[idx], f3, off);
            end else begin
                elat = (f3 == 3'd2) ? 2 : 4; enrd = (f3 == 3'd2) ? 0 : 1; enwr = 1; exp_stores++;
                ref_mem[idx] = ref_store(ref_mem[idx], f3, off, wd);
            end
            do_req(we, f3, addr, wd, rd, er, lat, nrd, nwr);
            checks++;
            if (rd !== erd || er !== ee) begin
                errors++;
                $display("FAIL rand_resp_%0d we=%b f3=%0d addr=%h rdata=%h err=%b required %h/%b",
                         i, we, f3, addr, rd, er, erd, ee);
            end
            checks++;
            if (lat != elat || nrd != enrd || nwr != enwr) begin
                errors++;
                $display("FAIL rand_timing_%0d lat=%0d rd=%0d wr=%0d required %0d/%0d/%0d",
                         i, lat, nrd, nwr, elat, enrd, enwr);
            end
            if (!ee && we) begin
                checks++;
                if (mem[idx] !== ref_mem[idx]) begin
                    errors++;
                    $display("FAIL rand_mem_%0d word=%0d got=%h required=%h", i, idx, mem[idx], ref_mem[idx]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = (i < 16) ? $urandom : 32'd0;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899_AABB;
        ref_mem[4] = 32'h8899_AABB;
        test_reset();
        test_loads();
        test_store_sb();
        test_errors();
        test_backpressure();
        test_stats();
        test_reset_mid();
        test_random();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit between the execute stage and the word-addressed data memory; directly upstream of the data memory, which it drives.
- Accepts one byte-addressed RISC-V load/store request at a time and converts it to word accesses.
- Stores sub-word data by read-modify-write and sign- or zero-extends load data.
- Uses valid/ready on the core side and single-cycle rd_en/wr_en strobes on the memory side.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the data memory.
- IDX_W, 10, word-index width; must equal log2(DEPTH_WORDS).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  1  request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.
- m_addr  out  32  word index to memory, equal to zero-extended req_addr[IDX_W+1:2].
- m_wr_dat  out  32  write data to memory.
- rd_en  out  1  memory read strobe.
- wr_en  out  1  memory write strobe.
- m_rd_dat  in  32  memory read data, valid the cycle after rd_en is sampled.
- stat_loads, stat_stores, stat_errs  out  16 each  event counters (see Optional Feature).

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0, resp_err=0; resp_rdata=0, m_addr=0, m_wr_dat=0; rd_en=0, wr_en=0; stats=0.
- rd_en, wr_en, m_addr and m_wr_dat are Moore outputs decoded from registered state and latched request fields.
- Accept: in IDLE, req_ready=1. A handshake (req_valid & req_ready at a rising edge) latches we, funct3, addr and wdata. req_ready=0 in every state other than IDLE.
- Error check at accept, in priority order:
  - illegal funct3 (011, 110, 111; 100/101 with we=1);
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠0;
  - addr[31:IDX_W+2]≠0.
  - Any error goes to RESP with resp_err=1 and resp_rdata=0. No rd_en or wr_en is issued.
- States and transitions:
  - IDLE: accepted load, or sub-word store → RD_REQ. Accepted SW → WR_REQ. Error → RESP.
  - RD_REQ: rd_en=1 for exactly one cycle → RD_WAIT.
  - RD_WAIT: sample m_rd_dat.
    - Load: select lane by addr[1:0] (byte) or addr[1] (half), extend (signed for B/H, zero for BU/HU, none for W), register into resp_rdata → RESP.
    - Store: merge wdata[7:0] or wdata[15:0] into the addressed lane of m_rd_dat; other lanes unchanged → WR_REQ.
  - WR_REQ: wr_en=1 for exactly one cycle, m_wr_dat = merged word (SB/SH) or wdata (SW) → RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready=1 at an edge → IDLE.
- Latency, counted from the accept edge to the first cycle resp_valid=1:
  - load: 3 cycles;
  - SW: 2 cycles;
  - SB/SH: 4 cycles;
  - error: 1 cycle.
- A new request is accepted no earlier than the cycle after the RESP handshake; there are no back-to-back overlaps.
- Lane mapping is little-endian: byte k = bits [8k+7:8k].
- reset asserted in any state:
  - returns to IDLE immediately;
  - rd_en and wr_en drop asynchronously;
  - the pending response is discarded.
  - If reset asserts before the WR_REQ edge, the memory word is unmodified.

Optional Feature:
- LSU_STATS_EN defined: stat_loads, stat_stores and stat_errs count completed load, completed store and error responses, incrementing at the RESP handshake. Each counter saturates at 0xFFFF and is cleared by reset.
- Undefined: all three outputs are tied to 0 and no counter flops exist.

Test Plan:
- Preload word 4 = 0x8899AABB. LB 0x13 → resp_rdata 0xFFFFFF88. LBU 0x13 → 0x00000088. resp_err=0 in both; resp_valid 3 cycles after accept.
- Preload as above. LH 0x12 → 0xFFFF8899. LHU 0x10 → 0x0000AABB. LW 0x10 → 0x8899AABB.
- SB addr 0x11, wdata 0x12345677 → one rd_en pulse, then one wr_en pulse with m_addr=4 and m_wr_dat=0x889977BB. A following LW 0x10 returns 0x889977BB.
- LW 0x12 → resp_err=1, resp_rdata=0 one cycle after accept, no rd_en/wr_en. Same result for funct3=011, and for LW 0x1000 (out of range).
- LW with resp_ready held 0 for 5 cycles → resp_valid stays 1 with resp_rdata stable, and req_ready=0 throughout. Handshake on cycle 6 → IDLE, req_ready=1 the next cycle.
- SH 0x10 with reset dropped during RD_WAIT → no wr_en, word 4 still 0x8899AABB, all outputs at reset values. After release, a LW 0x10 completes normally. With LSU_STATS_EN: stat_loads=1, stat_stores=0.
